// File: rtl/bcd_sched_pkg.sv
// Shared types and helpers for the scheduled-tick BCD up/down counter.
package bcd_sched_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;
    localparam bcd_t BCD_MIN = 4'd0;

    typedef enum logic {
        SEG_A = 1'b0,
        SEG_B = 1'b1
    } seg_t;

    function automatic int maxp(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit; inc/dec are the carry/borrow arriving from the lower digit.
module bcd_digit
    import bcd_sched_pkg::*;
#(
    parameter bcd_t INIT = BCD_MIN
) (
    input  logic clk,
    input  logic clr,
    input  logic inc,
    input  logic dec,
    output bcd_t q,
    output logic ripple
);

    bcd_t q_reg;
    bcd_t q_next;

    always_comb begin
        q_next = q_reg;
        if (inc && !dec) begin
            q_next = (q_reg == BCD_MAX) ? BCD_MIN : q_reg + 4'd1;
        end else if (dec && !inc) begin
            q_next = (q_reg == BCD_MIN) ? BCD_MAX : q_reg - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            q_reg <= INIT;
        end else begin
            q_reg <= q_next;
        end
    end

    // Carry out when stepping up from 9, borrow out when stepping down from 0.
    assign ripple = (inc && !dec && (q_reg == BCD_MAX)) ||
                    (dec && !inc && (q_reg == BCD_MIN));
    assign q      = q_reg;

endmodule

// File: rtl/bcd_sched_counter.sv
// Scheduled tick generator driving lock-step BCD up and down counters.
// Optional wrap outputs: define BCD_SCHED_WRAP_FLAG_EN.
module bcd_sched_counter
    import bcd_sched_pkg::*;
#(
    parameter int DIGITS    = 2,
    parameter int P0        = 1000,
    parameter int P1        = 4000,
    parameter int P2        = 3000,
    parameter int P3        = 2000,
    parameter int SEG_TICKS = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                clr,
    output logic                tick,
    output logic                seg,
    output logic [4*DIGITS-1:0] up,
    output logic [4*DIGITS-1:0] down
`ifdef BCD_SCHED_WRAP_FLAG_EN
    ,
    output logic                up_wrap,
    output logic                down_wrap
`endif
);

    localparam int PMAX  = maxp(P0, P1, P2, P3);
    localparam int PW    = $clog2(PMAX);
    localparam int KW    = $clog2(2 * SEG_TICKS);
    localparam int KLAST = 2 * SEG_TICKS - 1;

    // Periods are stored as terminal count (period-1) so PMAX = 2**PW still fits.
    function automatic logic [PW-1:0] last_of(input seg_t s, input logic odd);
        logic [PW-1:0] r;
        case ({s, odd})
            {SEG_A, 1'b0}: r = PW'(P0 - 1);
            {SEG_A, 1'b1}: r = PW'(P1 - 1);
            {SEG_B, 1'b0}: r = PW'(P2 - 1);
            default:       r = PW'(P3 - 1);
        endcase
        return r;
    endfunction

    logic          clear;
    logic [PW-1:0] cnt_reg,  cnt_next;
    logic [PW-1:0] last_reg, last_next;
    logic [KW-1:0] k_reg,    k_next;
    seg_t          seg_reg,  seg_next;
    logic          tick_reg;
    logic          hit;
    logic          adv;

    assign clear = rst || clr;

    always_comb begin
        hit       = (cnt_reg == last_reg);
        cnt_next  = hit ? '0 : cnt_reg + 1'b1;
        k_next    = (k_reg == KW'(KLAST)) ? '0 : k_reg + 1'b1;
        seg_next  = (k_next >= KW'(SEG_TICKS)) ? SEG_B : SEG_A;
        last_next = last_of(seg_next, k_next[0]);
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt_reg  <= '0;
            last_reg <= PW'(P0 - 1);
            k_reg    <= '0;
            seg_reg  <= SEG_A;
            tick_reg <= 1'b0;
        end else if (en) begin
            tick_reg <= hit;
            cnt_reg  <= cnt_next;
            if (hit) begin
                k_reg    <= k_next;
                seg_reg  <= seg_next;
                last_reg <= last_next;
            end
        end else begin
            // A tick in flight still ends after one cycle; nothing else moves.
            tick_reg <= 1'b0;
        end
    end

    assign tick = tick_reg;
    assign seg  = (seg_reg == SEG_B);
    assign adv  = tick_reg && en;

    logic [DIGITS:0] up_carry;
    logic [DIGITS:0] dn_borrow;

    assign up_carry[0]  = adv;
    assign dn_borrow[0] = adv;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            bcd_digit #(.INIT(BCD_MIN)) u_up (
                .clk    (clk),
                .clr    (clear),
                .inc    (up_carry[gi]),
                .dec    (1'b0),
                .q      (up[4*gi +: 4]),
                .ripple (up_carry[gi+1])
            );
            bcd_digit #(.INIT(BCD_MAX)) u_down (
                .clk    (clk),
                .clr    (clear),
                .inc    (1'b0),
                .dec    (dn_borrow[gi]),
                .q      (down[4*gi +: 4]),
                .ripple (dn_borrow[gi+1])
            );
        end
    endgenerate

`ifdef BCD_SCHED_WRAP_FLAG_EN
    logic up_wrap_reg;
    logic down_wrap_reg;

    always_ff @(posedge clk) begin
        if (clear) begin
            up_wrap_reg   <= 1'b0;
            down_wrap_reg <= 1'b0;
        end else begin
            up_wrap_reg   <= up_carry[DIGITS];
            down_wrap_reg <= dn_borrow[DIGITS];
        end
    end

    assign up_wrap   = up_wrap_reg;
    assign down_wrap = down_wrap_reg;
`else
    logic unused_ripple;
    assign unused_ripple = up_carry[DIGITS] ^ dn_borrow[DIGITS];
`endif

endmodule

// File: tb/tb_bcd_sched_counter.sv
// Directed bench for bcd_sched_counter (P0=4 P1=6 P2=5 P3=3 SEG_TICKS=4 DIGITS=2).
module tb_bcd_sched_counter;

    logic       clk = 1'b0;
    logic       rst, en, clr;
    logic       tick, seg;
    logic [7:0] up, down;
`ifdef BCD_SCHED_WRAP_FLAG_EN
    logic       up_wrap, down_wrap;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_sched_counter #(
        .DIGITS(2), .P0(4), .P1(6), .P2(5), .P3(3), .SEG_TICKS(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .clr       (clr),
        .tick      (tick),
        .seg       (seg),
        .up        (up),
        .down      (down)
`ifdef BCD_SCHED_WRAP_FLAG_EN
        ,
        .up_wrap   (up_wrap),
        .down_wrap (down_wrap)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] bcd(input int n);
        logic [3:0] hi, lo;
        hi = 4'(n / 10);
        lo = 4'(n % 10);
        return {hi, lo};
    endfunction

    function automatic logic [31:0] legal(input logic [7:0] a, input logic [7:0] b);
        return ((a[3:0] <= 4'd9) && (a[7:4] <= 4'd9) &&
                (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9)) ? 32'd1 : 32'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges from the reference point until tick is seen; -1 if it never comes.
    task automatic wait_tick(input int start, output int gap);
        gap = start;
        do begin
            step();
            gap++;
        end while (tick !== 1'b1 && gap < 60);
        if (tick !== 1'b1) gap = -1;
    endtask

    initial begin
        int periods[8];
        int gap;
        int start;
        periods = '{4, 6, 4, 6, 5, 3, 5, 3};

        rst = 1'b1; en = 1'b1; clr = 1'b0;
        repeat (3) step();
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_seg",  32'(seg),  32'd0);
        check("rst_up",   32'(up),   32'h00);
        check("rst_down", 32'(down), 32'h99);
        rst = 1'b0;

        // Ticks 1..100: schedule gaps, segment, one-cycle counter latency, wrap.
        start = 0;
        for (int i = 1; i <= 100; i++) begin
            wait_tick(start, gap);
            check($sformatf("gap%0d", i), 32'(gap), 32'(periods[(i-1) % 8]));
            check($sformatf("seg%0d", i), 32'(seg), ((i % 8) >= 4) ? 32'd1 : 32'd0);
            check($sformatf("up_pre%0d", i),   32'(up),   32'(bcd((i-1) % 100)));
            check($sformatf("down_pre%0d", i), 32'(down), 32'(bcd(99 - (i-1) % 100)));
            step();
            check($sformatf("up_post%0d", i),   32'(up),   32'(bcd(i % 100)));
            check($sformatf("down_post%0d", i), 32'(down), 32'(bcd(99 - i % 100)));
            check($sformatf("tick_width%0d", i), 32'(tick), 32'd0);
            check($sformatf("legal%0d", i), legal(up, down), 32'd1);
`ifdef BCD_SCHED_WRAP_FLAG_EN
            check($sformatf("up_wrap%0d", i),   32'(up_wrap),   (i == 100) ? 32'd1 : 32'd0);
            check($sformatf("down_wrap%0d", i), 32'(down_wrap), (i == 100) ? 32'd1 : 32'd0);
`endif
            start = 1;
        end

        // Freeze 7 cycles two cycles into a P2 interval.
        step();
`ifdef BCD_SCHED_WRAP_FLAG_EN
        check("wrap_drop_up",   32'(up_wrap),   32'd0);
        check("wrap_drop_down", 32'(down_wrap), 32'd0);
`endif
        en = 1'b0;
        for (int j = 0; j < 7; j++) begin
            step();
            check($sformatf("frz_tick%0d", j), 32'(tick), 32'd0);
        end
        check("frz_seg",  32'(seg),  32'd1);
        check("frz_up",   32'(up),   32'h00);
        check("frz_down", 32'(down), 32'h99);
        en = 1'b1;
        wait_tick(0, gap);
        check("frz_rest_gap", 32'(gap), 32'd3);
        check("frz_seg101",   32'(seg), 32'd1);
        step();
        check("up101",   32'(up),   32'h01);
        check("down101", 32'(down), 32'h98);

        // en drops while tick is high: pulse ends, counters hold.
        wait_tick(1, gap);
        check("gap102", 32'(gap), 32'd3);
        en = 1'b0;
        step();
        check("drop_tick", 32'(tick), 32'd0);
        check("drop_up",   32'(up),   32'h01);
        step();
        check("drop_tick2", 32'(tick), 32'd0);
        en = 1'b1;
        wait_tick(0, gap);
        check("gap103",   32'(gap),  32'd5);
        check("up103pre", 32'(up),   32'h01);
        step();
        check("up103",   32'(up),   32'h02);
        check("down103", 32'(down), 32'h97);

        wait_tick(1, gap);
        check("gap104", 32'(gap), 32'd3);
        check("seg104", 32'(seg), 32'd0);
        step();
        wait_tick(1, gap);
        check("gap105", 32'(gap), 32'd4);
        check("seg105", 32'(seg), 32'd0);

        // clr two cycles into the P1 interval.
        step();
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_up",   32'(up),   32'h00);
        check("clr_down", 32'(down), 32'h99);
        check("clr_seg",  32'(seg),  32'd0);
        check("clr_tick", 32'(tick), 32'd0);
        wait_tick(0, gap);
        check("clr_gap", 32'(gap), 32'd4);
        check("clr_seg_tick", 32'(seg), 32'd0);
        step();
        check("clr_up1", 32'(up), 32'h01);

        // rst and clr together.
        rst = 1'b1; clr = 1'b1;
        step();
        rst = 1'b0; clr = 1'b0;
        check("both_up",   32'(up),   32'h00);
        check("both_down", 32'(down), 32'h99);
        wait_tick(0, gap);
        check("both_gap", 32'(gap), 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
